// File: rtl/fetch_pkg.sv
// Shared types, opcodes and immediate decoders for the fetch front-end.
package fetch_pkg;

    localparam int DATA_WID = 32;

    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

    // One buffered fetch: where it came from, what it is, and how we predicted it.
    typedef struct packed {
        logic [DATA_WID-1:0] pc;
        logic [DATA_WID-1:0] inst;
        logic                pred_taken;
    } fetch_entry_t;

    // J-type immediate, sign-extended: imm[20|10:1|11|19:12] in inst[31:12].
    function automatic logic [DATA_WID-1:0] imm_j(input logic [DATA_WID-1:0] inst);
        return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    // B-type immediate, sign-extended: imm[12|10:5] in inst[31:25], imm[4:1|11] in inst[11:7].
    function automatic logic [DATA_WID-1:0] imm_b(input logic [DATA_WID-1:0] inst);
        return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of fetch entries between fetch and decode.
// Pointers wrap naturally at QUEUE_DEPTH (a power of two); count is one bit
// wider so that full and empty are distinguishable.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int QUEUE_DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enq,
    input  logic         deq,
    input  logic         flush,
    input  fetch_entry_t enq_data,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(QUEUE_DEPTH);

    fetch_entry_t     mem [QUEUE_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_enq;
    logic             do_deq;

    // Flush wins over both ports; a full queue refuses enqueue even while draining.
    assign do_enq = enq && !full && !flush;
    assign do_deq = deq && !empty && !flush;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Storage: cleared on reset so the head reads zero; flush leaves data in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_enq) begin
            mem[wr_ptr] <= enq_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_enq) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_enq, do_deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: PC register, static next-PC prediction and the decode queue.
//
// Decode handshake: an entry transfers on a clock edge where dec_valid and
// dec_ready are both high and predict_fail is low. dec_valid depends only on
// queue occupancy and never on dec_ready; once raised it stays high with
// stable dec_* data until the entry transfers or a flush/reset clears it.
module inst_fetch
    import fetch_pkg::*;
#(
    parameter int          QUEUE_DEPTH = 8,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    output logic [DATA_WID-1:0] pc_o,
    input  logic [DATA_WID-1:0] inst_i,
    input  logic                icache_stall_i,
    input  logic                predict_fail,
    input  logic [DATA_WID-1:0] redirect_pc,
    output logic                dec_valid,
    output logic [DATA_WID-1:0] dec_inst,
    output logic [DATA_WID-1:0] dec_pc,
    output logic                dec_pred_taken,
    input  logic                dec_ready
);

    logic [DATA_WID-1:0] next_pc;
    logic                pred_taken;
    logic                fetch_fire;
    logic                deq_fire;
    logic                q_full;
    logic                q_empty;
    fetch_entry_t        q_in;
    fetch_entry_t        q_head;

    // Static predictor: JAL and backward branches taken, everything else falls through.
    always_comb begin
        pred_taken = 1'b0;
        next_pc    = pc_o + 32'd4;
        if (inst_i[6:0] == OPCODE_JAL) begin
            pred_taken = 1'b1;
            next_pc    = pc_o + imm_j(inst_i);
        end else if (inst_i[6:0] == OPCODE_BRANCH && inst_i[31]) begin
            pred_taken = 1'b1;
            next_pc    = pc_o + imm_b(inst_i);
        end
    end

    assign fetch_fire = !icache_stall_i && !q_full && !predict_fail;
    assign deq_fire   = dec_valid && dec_ready && !predict_fail;

    assign q_in = '{pc: pc_o, inst: inst_i, pred_taken: pred_taken};

    // PC register: reset beats redirect, redirect beats fetch; stall or full holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_o <= RESET_PC;
        end else if (predict_fail) begin
            pc_o <= redirect_pc;
        end else if (fetch_fire) begin
            pc_o <= next_pc;
        end
    end

    fetch_queue #(
        .QUEUE_DEPTH(QUEUE_DEPTH)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .enq      (fetch_fire),
        .deq      (deq_fire),
        .flush    (predict_fail),
        .enq_data (q_in),
        .full     (q_full),
        .empty    (q_empty),
        .head     (q_head)
    );

    assign dec_valid      = !q_empty;
    assign dec_inst       = q_head.inst;
    assign dec_pc         = q_head.pc;
    assign dec_pred_taken = q_head.pred_taken;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a small instruction-cache model drives inst_i
// from pc_o, directed sequences push the expected decode entries, and a
// negedge monitor pops and compares every entry decode accepts.
module tb_inst_fetch;
  import fetch_pkg::*;

  localparam int EW = $bits(fetch_entry_t);

  localparam logic [31:0] NOP      = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] JAL_P100 = 32'h1000_006F;  // jal x0,+0x100
  localparam logic [31:0] BEQ_M8   = 32'hFE00_0CE3;  // beq x0,x0,-8
  localparam logic [31:0] BEQ_P8   = 32'h0000_0463;  // beq x0,x0,+8
  localparam logic [31:0] JUNK     = 32'hDEAD_BEEF;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_o;
  logic [31:0] inst_i;
  logic        icache_stall_i;
  logic        predict_fail;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic        dec_pred_taken;
  logic        dec_ready;

  always #5 clk = ~clk;

  inst_fetch #(.QUEUE_DEPTH(8), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_o           (pc_o),
    .inst_i         (inst_i),
    .icache_stall_i (icache_stall_i),
    .predict_fail   (predict_fail),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_inst       (dec_inst),
    .dec_pc         (dec_pc),
    .dec_pred_taken (dec_pred_taken),
    .dec_ready      (dec_ready)
  );

  // Instruction cache model: NOPs everywhere unless the program is enabled.
  logic prog_on;
  logic beq_fwd;
  always_comb begin
    inst_i = NOP;
    if (icache_stall_i) inst_i = JUNK;
    else if (prog_on) begin
      if (pc_o == 32'h10) inst_i = JAL_P100;
      else if (pc_o == 32'h20) inst_i = beq_fwd ? BEQ_P8 : BEQ_M8;
    end
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] inst, input logic taken);
    exp_q.push_back({pc, inst, taken});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Monitor: an accepted head transfers on the next posedge.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!rst && !predict_fail && dec_valid && dec_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got pc %h inst %h, required no entry", dec_pc, dec_inst);
      end else begin
        e = exp_q.pop_front();
        if ({dec_pc, dec_inst, dec_pred_taken} !== e) begin
          n_fail++;
          $display("FAIL sb_entry: got pc %h inst %h tk %b, required pc %h inst %h tk %b",
                   dec_pc, dec_inst, dec_pred_taken, e[64:33], e[32:1], e[0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle backend redirect; leaves the queue empty with pc_o = pc.
  task automatic redirect(input logic [31:0] pc);
    predict_fail = 1'b1;
    redirect_pc  = pc;
    dec_ready    = 1'b0;
    step();
    predict_fail = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; predict_fail = 1'b0; redirect_pc = '0; icache_stall_i = 1'b0;
    dec_ready = 1'b1; prog_on = 1'b0; beq_fwd = 1'b0;
    step(); step();
    @(negedge clk);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_valid", dec_valid, 0);
    chk("rst_inst", dec_inst, 0);
    chk("rst_dpc", dec_pc, 0);
    chk("rst_taken", dec_pred_taken, 0);
    step();
    rst = 1'b0;

    // Sequential hit stream, decode always ready.
    push_exp(32'h0, NOP, 0); push_exp(32'h4, NOP, 0); push_exp(32'h8, NOP, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("seq_pc", pc_o, 32'(4 * i));
      if (i > 0) begin
        chk("seq_valid", dec_valid, 1);
        chk("seq_dpc", dec_pc, 32'(4 * (i - 1)));
      end
      step();
    end
    dec_ready = 1'b0;

    // JAL +0x100 at 0x10.
    prog_on = 1'b1;
    redirect(32'h10);
    dec_ready = 1'b1;
    push_exp(32'h10, JAL_P100, 1);
    @(negedge clk);
    chk("jal_pc0", pc_o, 32'h10);
    chk("jal_valid0", dec_valid, 0);
    step();
    @(negedge clk);
    chk("jal_next", pc_o, 32'h110);
    chk("jal_taken", dec_pred_taken, 1);
    chk("jal_dpc", dec_pc, 32'h10);
    step();
    dec_ready = 1'b0;

    // Backward BEQ -8 at 0x20.
    beq_fwd = 1'b0;
    redirect(32'h20);
    dec_ready = 1'b1;
    push_exp(32'h20, BEQ_M8, 1);
    @(negedge clk);
    chk("beqb_pc0", pc_o, 32'h20);
    step();
    @(negedge clk);
    chk("beqb_next", pc_o, 32'h18);
    chk("beqb_taken", dec_pred_taken, 1);
    step();
    dec_ready = 1'b0;

    // Forward BEQ +8 at 0x20: not taken.
    beq_fwd = 1'b1;
    redirect(32'h20);
    dec_ready = 1'b1;
    push_exp(32'h20, BEQ_P8, 0);
    @(negedge clk);
    step();
    @(negedge clk);
    chk("beqf_next", pc_o, 32'h24);
    chk("beqf_taken", dec_pred_taken, 0);
    step();
    dec_ready = 1'b0;

    // Fill to full with decode stalled, then drain.
    prog_on = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (10) step();
    @(negedge clk);
    chk("full_pc", pc_o, 32'h20);
    chk("full_valid", dec_valid, 1);
    chk("full_head", dec_pc, 32'h0);
    for (int k = 0; k < 10; k++) push_exp(32'(4 * k), NOP, 0);
    step();
    dec_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("drain_valid", dec_valid, 1);
      if (k < 2) chk("drain_pc_hold", pc_o, 32'h20);
      if (k == 2) chk("drain_pc_resume", pc_o, 32'h24);
      step();
    end
    dec_ready = 1'b0;

    // Three-cycle cache miss at 0x40.
    redirect(32'h40);
    dec_ready = 1'b1;
    icache_stall_i = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk("stall_pc", pc_o, 32'h40);
      chk("stall_valid", dec_valid, 0);
      step();
    end
    icache_stall_i = 1'b0;
    push_exp(32'h40, NOP, 0);
    @(negedge clk);
    chk("stall_pc_end", pc_o, 32'h40);
    chk("stall_valid_end", dec_valid, 0);
    step();
    @(negedge clk);
    chk("unstall_pc", pc_o, 32'h44);
    chk("unstall_dpc", dec_pc, 32'h40);
    step();
    dec_ready = 1'b0;

    // Flush with five entries buffered and decode ready.
    redirect(32'h80);
    repeat (5) step();
    predict_fail = 1'b1;
    redirect_pc  = 32'h200;
    dec_ready    = 1'b1;
    @(negedge clk);
    chk("preflush_valid", dec_valid, 1);
    chk("preflush_head", dec_pc, 32'h80);
    step();
    predict_fail = 1'b0;
    push_exp(32'h200, NOP, 0);
    @(negedge clk);
    chk("flush_valid", dec_valid, 0);
    chk("flush_pc", pc_o, 32'h200);
    step();
    @(negedge clk);
    chk("redir_valid", dec_valid, 1);
    chk("redir_head", dec_pc, 32'h200);
    step();
    dec_ready = 1'b0;

    // Reset has priority over a simultaneous redirect.
    rst = 1'b1;
    predict_fail = 1'b1;
    redirect_pc = 32'h300;
    step();
    rst = 1'b0;
    predict_fail = 1'b0;
    @(negedge clk);
    chk("rstprio_pc", pc_o, 32'h0);
    chk("rstprio_valid", dec_valid, 0);
    chk("rstprio_inst", dec_inst, 0);

    chk("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
